// File: rtl/ov7670_pixel_capture.sv
// rtl/ov7670_pixel_capture.sv - OV7670 byte-pair to RGB565 capture with frame skip, pclk domain.
// Optional CAPTURE_TEST_PATTERN_EN replaces sensor pixels with 8 vertical colour bars.
module ov7670_pixel_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        vsync_pos,
  output logic        frame_active,
  output logic        line_err,
  output logic [15:0] frame_cnt
);

  localparam int XW  = $clog2(H_ACTIVE + 1);
  localparam int YW  = $clog2(V_ACTIVE + 1);
  localparam int BW  = $clog2(2 * H_ACTIVE + 2);
  localparam int SKW = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);

  localparam logic [SKW-1:0] SKIP_LAST  = SKW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
  localparam logic [XW-1:0]  X_MAX      = XW'(H_ACTIVE);
  localparam logic [YW-1:0]  Y_MAX      = YW'(V_ACTIVE);
  localparam logic [BW-1:0]  LINE_BYTES = BW'(2 * H_ACTIVE);
  localparam logic [BW-1:0]  BYTE_SAT   = BW'(2 * H_ACTIVE + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_WAIT_VS,
    ST_CAPTURE
  } state_t;

  state_t state, state_nxt;

  logic           r_vsync, r_vsync_d, r_href, r_href_d;
  logic [7:0]     r_data;
  logic [SKW-1:0] skip_cnt;
  logic           phase;
  logic [7:0]     hi_byte;
  logic [XW-1:0]  x_cnt;
  logic [YW-1:0]  y_cnt;
  logic [BW-1:0]  byte_cnt;

  logic        vs_rise, href_fall, capturing, frame_start;
  logic        line_clear, byte_in, pix_done, pix_emit;
  logic [15:0] pix_word;

  // Sensor pins are registered once; every decision below uses these copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync   <= 1'b0;
      r_vsync_d <= 1'b0;
      r_href    <= 1'b0;
      r_href_d  <= 1'b0;
      r_data    <= 8'd0;
    end else begin
      r_vsync   <= cam_vsync;
      r_vsync_d <= r_vsync;
      r_href    <= cam_href;
      r_href_d  <= r_href;
      r_data    <= cam_data;
    end
  end

  assign vs_rise     = r_vsync & ~r_vsync_d;
  assign href_fall   = ~r_href & r_href_d;
  assign capturing   = (state == ST_CAPTURE) && cap_en;
  assign frame_start = vs_rise && cap_en && ((state == ST_WAIT_VS) || (state == ST_CAPTURE));

  assign line_clear  = !capturing || vs_rise || href_fall;
  assign byte_in     = capturing && !vs_rise && r_href;
  assign pix_done    = byte_in && phase;
  assign pix_emit    = pix_done && (x_cnt != X_MAX) && (y_cnt != Y_MAX);

  assign frame_active = (state == ST_CAPTURE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (cap_en) state_nxt = (SKIP_FRAMES == 0) ? ST_WAIT_VS : ST_SKIP;
      ST_SKIP:    if (vs_rise && (skip_cnt == SKIP_LAST)) state_nxt = ST_WAIT_VS;
      ST_WAIT_VS: if (vs_rise) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_CAPTURE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (!cap_en) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || (state != ST_SKIP)) begin
      skip_cnt <= '0;
    end else if (vs_rise) begin
      skip_cnt <= skip_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_pos <= 1'b0;
      frame_cnt <= 16'd0;
      line_err  <= 1'b0;
    end else begin
      vsync_pos <= frame_start;
      if (frame_start) frame_cnt <= frame_cnt + 16'd1;
      // A bad line ending in the same cycle as a frame start still latches.
      if (href_fall && capturing && (byte_cnt != LINE_BYTES)) begin
        line_err <= 1'b1;
      end else if (frame_start) begin
        line_err <= 1'b0;
      end
    end
  end

`ifdef CAPTURE_TEST_PATTERN_EN
  localparam logic [XW-1:0] BAR_LAST = XW'(H_ACTIVE / 8 - 1);

  logic [XW-1:0] bar_px;
  logic [2:0]    bar_idx;

  // Bar position tracks x incrementally so no divider is needed.
  always_ff @(posedge clk) begin
    if (rst || line_clear) begin
      bar_px  <= '0;
      bar_idx <= 3'd0;
    end else if (pix_done && (x_cnt != X_MAX)) begin
      if (bar_px == BAR_LAST) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px <= bar_px + 1'b1;
      end
    end
  end

  always_comb begin
    pix_word = 16'h0000;
    case (bar_idx)
      3'd0: pix_word = 16'hFFFF;
      3'd1: pix_word = 16'hFFE0;
      3'd2: pix_word = 16'h07FF;
      3'd3: pix_word = 16'h07E0;
      3'd4: pix_word = 16'hF81F;
      3'd5: pix_word = 16'hF800;
      3'd6: pix_word = 16'h001F;
      default: pix_word = 16'h0000;
    endcase
  end
`else
  assign pix_word = {hi_byte, r_data};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= 1'b0;
      hi_byte   <= 8'd0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      byte_cnt  <= '0;
      pix_valid <= 1'b0;
      pix_data  <= 16'd0;
    end else begin
      pix_valid <= pix_emit;
      if (pix_emit) pix_data <= pix_word;

      if (!capturing || vs_rise) begin
        y_cnt <= '0;
      end else if (href_fall && (x_cnt != '0) && (y_cnt != Y_MAX)) begin
        y_cnt <= y_cnt + 1'b1;
      end

      // Any odd trailing byte is dropped here simply by resetting phase.
      if (line_clear) begin
        phase    <= 1'b0;
        x_cnt    <= '0;
        byte_cnt <= '0;
      end else if (byte_in) begin
        phase <= ~phase;
        if (byte_cnt != BYTE_SAT) byte_cnt <= byte_cnt + 1'b1;
        if (!phase) hi_byte <= r_data;
        if (pix_done && (x_cnt != X_MAX)) x_cnt <= x_cnt + 1'b1;
      end
    end
  end

endmodule
